// File: rtl/hazard_detection_unit.sv
// ---------------------------------------------------------------------------
// hazard_detection_unit
//
// Purpose:
//   Hazard detector for the ID stage of a 5-stage MIPS pipeline. It detects
//   load-use hazards and data hazards for a BEQ that resolves in ID. On a
//   hazard it holds the PC and the IF/ID register and asks the main control
//   decoder for a bubble in ID/EX. A BEQ that depends on a load still in EX
//   needs two stall cycles; the second one is the HOLD1 state of a small FSM.
//   Stall cycles are tallied in two saturating statistics counters.
//
// Ports:
//   clk              in   1      pipeline clock, rising edge
//   rst_n            in   1      asynchronous active-low reset
//   ifid_opcode      in   6      opcode of the instruction in IF/ID
//   ifid_rs          in   5      rs field in IF/ID
//   ifid_rt          in   5      rt field in IF/ID
//   idex_mem_read    in   1      ID/EX MemRead (load in EX)
//   idex_reg_write   in   1      ID/EX RegWrite
//   idex_rt          in   5      ID/EX rt (load destination)
//   idex_wreg        in   5      ID/EX write register after the RegDst mux
//   exmem_mem_read   in   1      EX/MEM MemRead
//   exmem_rt         in   5      EX/MEM rt (load destination)
//   clr_stats        in   1      synchronous clear of both counters
//   hazard_detected  out  1      1 = control decoder forces a bubble
//   pc_write         out  1      0 = hold PC
//   ifid_write       out  1      0 = hold IF/ID
//   hold_active      out  1      1 while the FSM is in HOLD1
//   lu_stall_cnt     out  CNT_W  load-use stall cycles, saturating
//   br_stall_cnt     out  CNT_W  branch-in-ID stall cycles, saturating
// ---------------------------------------------------------------------------
module hazard_detection_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       ifid_opcode,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_mem_read,
  input  logic             idex_reg_write,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       idex_wreg,
  input  logic             exmem_mem_read,
  input  logic [4:0]       exmem_rt,
  input  logic             clr_stats,
  output logic             hazard_detected,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             hold_active,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] br_stall_cnt
);

  // Opcodes that matter to the decode.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // FSM encoding.
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_HOLD1 = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A producer register x collides with the ID instruction when it is not $0
  // and equals rs, or equals rt for instructions that actually read rt.
  function automatic logic reg_match(
    input logic [4:0] x,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       use_rt
  );
    return (x != 5'd0) && ((x == rs) || (use_rt && (x == rt)));
  endfunction

  // -------------------------------------------------------------------------
  // Decode of the instruction in ID
  // -------------------------------------------------------------------------
  logic is_beq;
  logic uses_rt;

  assign is_beq  = (ifid_opcode == OP_BEQ);
  assign uses_rt = (ifid_opcode == OP_RTYPE) ||
                   (ifid_opcode == OP_BEQ)   ||
                   (ifid_opcode == OP_SW);

  // -------------------------------------------------------------------------
  // Hazard terms
  // -------------------------------------------------------------------------
  logic m_idex_rt;
  logic m_idex_wreg;
  logic m_exmem_rt;
  logic lu_term;
  logic br_ld_term;
  logic br_1_term;

  assign m_idex_rt   = reg_match(idex_rt,   ifid_rs, ifid_rt, uses_rt);
  assign m_idex_wreg = reg_match(idex_wreg, ifid_rs, ifid_rt, uses_rt);
  assign m_exmem_rt  = reg_match(exmem_rt,  ifid_rs, ifid_rt, uses_rt);

  // A load feeding a non-branch consumer: one stall, forwarding covers the rest.
  assign lu_term    = idex_mem_read && m_idex_rt && !is_beq;
  // A load in EX feeding a branch in ID: the data is only available after MEM,
  // so two stall cycles are needed.
  assign br_ld_term = is_beq && idex_mem_read && m_idex_rt;
  // An ALU result in EX, or a load in MEM, feeding a branch in ID: one stall.
  // The ALU case excludes loads, which are handled by br_ld_term.
  assign br_1_term  = is_beq &&
                      ((idex_reg_write && !idex_mem_read && m_idex_wreg) ||
                       (exmem_mem_read && m_exmem_rt));

  // -------------------------------------------------------------------------
  // FSM and stall classification
  // -------------------------------------------------------------------------
  logic [0:0] state_reg;
  logic [0:0] state_next;
  logic       stall;
  logic       lu_inc;
  logic       br_inc;

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    lu_inc     = 1'b0;
    br_inc     = 1'b0;
    case (state_reg)
      ST_RUN: begin
        stall = lu_term || br_ld_term || br_1_term;
        if (br_ld_term) begin
          state_next = ST_HOLD1;
        end
        // Branch terms take priority, so each stall cycle counts only once.
        if (br_ld_term || br_1_term) begin
          br_inc = 1'b1;
        end else if (lu_term) begin
          lu_inc = 1'b1;
        end
      end
      ST_HOLD1: begin
        // Second cycle of a load-to-branch stall. The load has moved into
        // MEM, so br_1_term would fire too; the inputs are ignored here so the
        // cycle is counted exactly once.
        stall      = 1'b1;
        br_inc     = 1'b1;
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: combinational, masked to idle while reset is asserted
  // -------------------------------------------------------------------------
  assign hazard_detected = rst_n && stall;
  assign pc_write        = !hazard_detected;
  assign ifid_write      = !hazard_detected;
  assign hold_active     = rst_n && (state_reg == ST_HOLD1);

  // -------------------------------------------------------------------------
  // Saturating statistics counters: index 0 = load-use, 1 = branch
  // -------------------------------------------------------------------------
  logic [1:0] cnt_inc;

  assign cnt_inc = {br_inc, lu_inc};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (clr_stats) begin
          // Clear wins over an increment in the same cycle.
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign lu_stall_cnt = g_cnt[0].cnt_reg;
  assign br_stall_cnt = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_detection_unit
//
// Self-checking bench for hazard_detection_unit. Each scenario task drives one
// row of inputs per cycle (just after the rising edge), pushes the expected
// {hazard_detected, pc_write, ifid_write, hold_active} plus the counter values
// onto a scoreboard, and pops/compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_detection_unit;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;

  // {hazard_detected, pc_write, ifid_write, hold_active}
  localparam logic [3:0] IDLE  = 4'b0110;
  localparam logic [3:0] STALL = 4'b1000;
  localparam logic [3:0] HOLD  = 4'b1001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  ifid_opcode = '0;
  logic [4:0]  ifid_rs = '0;
  logic [4:0]  ifid_rt = '0;
  logic        idex_mem_read = 1'b0;
  logic        idex_reg_write = 1'b0;
  logic [4:0]  idex_rt = '0;
  logic [4:0]  idex_wreg = '0;
  logic        exmem_mem_read = 1'b0;
  logic [4:0]  exmem_rt = '0;
  logic        clr_stats = 1'b0;
  logic        hazard_detected;
  logic        pc_write;
  logic        ifid_write;
  logic        hold_active;
  logic [15:0] lu_stall_cnt;
  logic [15:0] br_stall_cnt;
  logic [3:0]  ctl;

  always #5 clk = ~clk;

  hazard_detection_unit #(.CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ifid_opcode     (ifid_opcode),
    .ifid_rs         (ifid_rs),
    .ifid_rt         (ifid_rt),
    .idex_mem_read   (idex_mem_read),
    .idex_reg_write  (idex_reg_write),
    .idex_rt         (idex_rt),
    .idex_wreg       (idex_wreg),
    .exmem_mem_read  (exmem_mem_read),
    .exmem_rt        (exmem_rt),
    .clr_stats       (clr_stats),
    .hazard_detected (hazard_detected),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .hold_active     (hold_active),
    .lu_stall_cnt    (lu_stall_cnt),
    .br_stall_cnt    (br_stall_cnt)
  );

  assign ctl = {hazard_detected, pc_write, ifid_write, hold_active};

  typedef struct {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       imr;
    logic       irw;
    logic [4:0] irt;
    logic [4:0] iwreg;
    logic       emr;
    logic [4:0] ert;
    logic       clr;
    logic [3:0] ctl;
    logic       dlu;
    logic       dbr;
  } row_t;

  typedef struct {
    logic [3:0]  ctl;
    logic [15:0] lu;
    logic [15:0] br;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_lu = '0;
  logic [15:0] exp_br = '0;

  function automatic row_t mk(
    input logic [5:0] op,  input logic [4:0] rs,  input logic [4:0] rt,
    input logic imr,       input logic irw,
    input logic [4:0] irt, input logic [4:0] iwreg,
    input logic emr,       input logic [4:0] ert, input logic clr,
    input logic [3:0] c,   input logic dlu,       input logic dbr
  );
    row_t r;
    r.op = op; r.rs = rs; r.rt = rt; r.imr = imr; r.irw = irw;
    r.irt = irt; r.iwreg = iwreg; r.emr = emr; r.ert = ert; r.clr = clr;
    r.ctl = c; r.dlu = dlu; r.dbr = dbr;
    return r;
  endfunction

  // Expected counter value after the next edge.
  function automatic logic [15:0] next_cnt(input logic [15:0] c, input logic inc,
                                           input logic clr);
    if (clr) return 16'h0000;
    if (inc && c != 16'hFFFF) return c + 16'h0001;
    return c;
  endfunction

  task automatic apply(input row_t r);
    ifid_opcode    = r.op;
    ifid_rs        = r.rs;
    ifid_rt        = r.rt;
    idex_mem_read  = r.imr;
    idex_reg_write = r.irw;
    idex_rt        = r.irt;
    idex_wreg      = r.iwreg;
    exmem_mem_read = r.emr;
    exmem_rt       = r.ert;
    clr_stats      = r.clr;
  endtask

  task automatic test_reset();
    exp_t e;
    #1 rst_n = 1'b0;
    // Load-use inputs present during reset must stay masked.
    apply(mk(OP_R, 5'd2, 5'd7, 1, 0, 5'd2, 5'd0, 0, 5'd0, 0, STALL, 0, 0));
    sb.push_back('{IDLE, 16'h0000, 16'h0000});
    @(negedge clk);
    e = sb.pop_front();
    vectors++;
    $display("[reset] ctl=%b lu=%h br=%h", ctl, lu_stall_cnt, br_stall_cnt);
    if ({ctl, lu_stall_cnt, br_stall_cnt} !== {e.ctl, e.lu, e.br}) begin
      miscompares++;
      $display("FAIL reset ctl/lu/br got %b/%h/%h want %b/%h/%h",
               ctl, lu_stall_cnt, br_stall_cnt, e.ctl, e.lu, e.br);
    end
    #2;
    apply(mk(OP_R, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, IDLE, 0, 0));
    rst_n = 1'b1;
    exp_lu = '0;
    exp_br = '0;
  endtask

  task automatic test_load_use();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(OP_R, 5'd2, 5'd7, 1, 0, 5'd2, 5'd0, 0, 5'd0, 0, STALL, 1, 0));
    rows.push_back(mk(OP_R, 5'd2, 5'd7, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, IDLE,  0, 0));
    rows.push_back(mk(OP_R, 5'd7, 5'd2, 1, 0, 5'd2, 5'd0, 0, 5'd0, 0, STALL, 1, 0));
    rows.push_back(mk(OP_R, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, IDLE,  0, 0));
    foreach (rows[i]) begin
      @(posedge clk); #1;
      apply(rows[i]);
      sb.push_back('{rows[i].ctl, exp_lu, exp_br});
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      $display("[load_use %0d] ctl=%b lu=%h br=%h", i, ctl, lu_stall_cnt, br_stall_cnt);
      if ({ctl, lu_stall_cnt, br_stall_cnt} !== {e.ctl, e.lu, e.br}) begin
        miscompares++;
        $display("FAIL load_use[%0d] ctl/lu/br got %b/%h/%h want %b/%h/%h",
                 i, ctl, lu_stall_cnt, br_stall_cnt, e.ctl, e.lu, e.br);
      end
      exp_lu = next_cnt(exp_lu, rows[i].dlu, rows[i].clr);
      exp_br = next_cnt(exp_br, rows[i].dbr, rows[i].clr);
    end
  endtask

  task automatic test_branch_load();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(OP_BEQ, 5'd3, 5'd9, 1, 0, 5'd3, 5'd0, 0, 5'd0, 0, STALL, 0, 1));
    rows.push_back(mk(OP_BEQ, 5'd3, 5'd9, 0, 0, 5'd0, 5'd0, 1, 5'd3, 0, HOLD,  0, 1));
    rows.push_back(mk(OP_BEQ, 5'd3, 5'd9, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, IDLE,  0, 0));
    // Load-to-branch through rt, with all inputs idle during HOLD1.
    rows.push_back(mk(OP_BEQ, 5'd1, 5'd3, 1, 0, 5'd3, 5'd0, 0, 5'd0, 0, STALL, 0, 1));
    rows.push_back(mk(OP_R,   5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, HOLD,  0, 1));
    rows.push_back(mk(OP_R,   5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, IDLE,  0, 0));
    foreach (rows[i]) begin
      @(posedge clk); #1;
      apply(rows[i]);
      sb.push_back('{rows[i].ctl, exp_lu, exp_br});
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      $display("[branch_load %0d] ctl=%b lu=%h br=%h", i, ctl, lu_stall_cnt, br_stall_cnt);
      if ({ctl, lu_stall_cnt, br_stall_cnt} !== {e.ctl, e.lu, e.br}) begin
        miscompares++;
        $display("FAIL branch_load[%0d] ctl/lu/br got %b/%h/%h want %b/%h/%h",
                 i, ctl, lu_stall_cnt, br_stall_cnt, e.ctl, e.lu, e.br);
      end
      exp_lu = next_cnt(exp_lu, rows[i].dlu, rows[i].clr);
      exp_br = next_cnt(exp_br, rows[i].dbr, rows[i].clr);
    end
  endtask

  task automatic test_branch_alu();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(OP_BEQ, 5'd9, 5'd4, 0, 1, 5'd0, 5'd4, 0, 5'd0, 0, STALL, 0, 1));
    rows.push_back(mk(OP_BEQ, 5'd9, 5'd4, 0, 0, 5'd0, 5'd4, 0, 5'd0, 0, IDLE,  0, 0));
    rows.push_back(mk(OP_BEQ, 5'd0, 5'd0, 0, 1, 5'd0, 5'd0, 0, 5'd0, 0, IDLE,  0, 0));
    rows.push_back(mk(OP_LW,  5'd0, 5'd5, 1, 0, 5'd5, 5'd0, 0, 5'd0, 0, IDLE,  0, 0));
    rows.push_back(mk(OP_SW,  5'd0, 5'd5, 1, 0, 5'd5, 5'd0, 0, 5'd0, 0, STALL, 1, 0));
    rows.push_back(mk(OP_BEQ, 5'd6, 5'd1, 0, 0, 5'd0, 5'd0, 1, 5'd6, 0, STALL, 0, 1));
    // Load in EX whose write reg matches but rt does not: no branch stall.
    rows.push_back(mk(OP_BEQ, 5'd6, 5'd1, 1, 1, 5'd0, 5'd6, 0, 5'd0, 0, IDLE,  0, 0));
    rows.push_back(mk(OP_R,   5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, IDLE,  0, 0));
    foreach (rows[i]) begin
      @(posedge clk); #1;
      apply(rows[i]);
      sb.push_back('{rows[i].ctl, exp_lu, exp_br});
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      $display("[branch_alu %0d] ctl=%b lu=%h br=%h", i, ctl, lu_stall_cnt, br_stall_cnt);
      if ({ctl, lu_stall_cnt, br_stall_cnt} !== {e.ctl, e.lu, e.br}) begin
        miscompares++;
        $display("FAIL branch_alu[%0d] ctl/lu/br got %b/%h/%h want %b/%h/%h",
                 i, ctl, lu_stall_cnt, br_stall_cnt, e.ctl, e.lu, e.br);
      end
      exp_lu = next_cnt(exp_lu, rows[i].dlu, rows[i].clr);
      exp_br = next_cnt(exp_br, rows[i].dbr, rows[i].clr);
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(OP_BEQ, 5'd3, 5'd0, 1, 0, 5'd3, 5'd0, 0, 5'd0, 0, STALL, 0, 1));
    rows.push_back(mk(OP_R,   5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, HOLD,  0, 1));
    rows.push_back(mk(OP_R,   5'd8, 5'd0, 1, 0, 5'd8, 5'd0, 0, 5'd0, 0, STALL, 1, 0));
    rows.push_back(mk(OP_R,   5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, IDLE,  0, 0));
    rows.push_back(mk(OP_BEQ, 5'd3, 5'd0, 1, 0, 5'd3, 5'd0, 0, 5'd0, 0, STALL, 0, 1));
    rows.push_back(mk(OP_BEQ, 5'd3, 5'd0, 1, 0, 5'd3, 5'd0, 0, 5'd0, 0, HOLD,  0, 1));
    rows.push_back(mk(OP_BEQ, 5'd3, 5'd0, 1, 0, 5'd3, 5'd0, 0, 5'd0, 0, STALL, 0, 1));
    rows.push_back(mk(OP_R,   5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, HOLD,  0, 1));
    rows.push_back(mk(OP_R,   5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, IDLE,  0, 0));
    foreach (rows[i]) begin
      @(posedge clk); #1;
      apply(rows[i]);
      sb.push_back('{rows[i].ctl, exp_lu, exp_br});
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      $display("[back_to_back %0d] ctl=%b lu=%h br=%h", i, ctl, lu_stall_cnt, br_stall_cnt);
      if ({ctl, lu_stall_cnt, br_stall_cnt} !== {e.ctl, e.lu, e.br}) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] ctl/lu/br got %b/%h/%h want %b/%h/%h",
                 i, ctl, lu_stall_cnt, br_stall_cnt, e.ctl, e.lu, e.br);
      end
      exp_lu = next_cnt(exp_lu, rows[i].dlu, rows[i].clr);
      exp_br = next_cnt(exp_br, rows[i].dbr, rows[i].clr);
    end
  endtask

  task automatic test_saturation();
    row_t rows[$];
    exp_t e;
    row_t lu_row;
    lu_row = mk(OP_R, 5'd2, 5'd0, 1, 0, 5'd2, 5'd0, 0, 5'd0, 0, STALL, 1, 0);
    // Clear both counters.
    rows.push_back(mk(OP_R, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 1, IDLE, 0, 0));
    foreach (rows[i]) begin
      @(posedge clk); #1;
      apply(rows[i]);
      sb.push_back('{rows[i].ctl, exp_lu, exp_br});
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      $display("[saturation clr] ctl=%b lu=%h br=%h", ctl, lu_stall_cnt, br_stall_cnt);
      if ({ctl, lu_stall_cnt, br_stall_cnt} !== {e.ctl, e.lu, e.br}) begin
        miscompares++;
        $display("FAIL saturation_clr ctl/lu/br got %b/%h/%h want %b/%h/%h",
                 ctl, lu_stall_cnt, br_stall_cnt, e.ctl, e.lu, e.br);
      end
      exp_lu = next_cnt(exp_lu, rows[i].dlu, rows[i].clr);
      exp_br = next_cnt(exp_br, rows[i].dbr, rows[i].clr);
    end
    // Run the load-use counter up to 16'hFFFD, then step it to the limit.
    @(posedge clk); #1;
    apply(lu_row);
    repeat (65533) @(posedge clk);
    exp_lu = 16'hFFFE;
    rows.delete();
    rows.push_back(lu_row);
    rows.push_back(lu_row);
    rows.push_back(mk(OP_R, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, IDLE,  0, 0));
    rows.push_back(mk(OP_R, 5'd2, 5'd0, 1, 0, 5'd2, 5'd0, 0, 5'd0, 1, STALL, 1, 0));
    rows.push_back(mk(OP_R, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, IDLE,  0, 0));
    foreach (rows[i]) begin
      @(negedge clk);
      if (i != 0) begin
        @(posedge clk);
      end
      #1;
      apply(rows[i]);
      sb.push_back('{rows[i].ctl, exp_lu, exp_br});
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      $display("[saturation %0d] ctl=%b lu=%h br=%h", i, ctl, lu_stall_cnt, br_stall_cnt);
      if ({ctl, lu_stall_cnt, br_stall_cnt} !== {e.ctl, e.lu, e.br}) begin
        miscompares++;
        $display("FAIL saturation[%0d] ctl/lu/br got %b/%h/%h want %b/%h/%h",
                 i, ctl, lu_stall_cnt, br_stall_cnt, e.ctl, e.lu, e.br);
      end
      exp_lu = next_cnt(exp_lu, rows[i].dlu, rows[i].clr);
      exp_br = next_cnt(exp_br, rows[i].dbr, rows[i].clr);
    end
  endtask

  task automatic test_reset_in_hold();
    exp_t e;
    // Load-to-branch hazard enters HOLD1 on the next edge.
    @(posedge clk); #1;
    apply(mk(OP_BEQ, 5'd3, 5'd0, 1, 0, 5'd3, 5'd0, 0, 5'd0, 0, STALL, 0, 1));
    sb.push_back('{STALL, exp_lu, exp_br});
    @(negedge clk);
    e = sb.pop_front();
    vectors++;
    $display("[reset_in_hold 0] ctl=%b lu=%h br=%h", ctl, lu_stall_cnt, br_stall_cnt);
    if ({ctl, lu_stall_cnt, br_stall_cnt} !== {e.ctl, e.lu, e.br}) begin
      miscompares++;
      $display("FAIL reset_in_hold[0] ctl/lu/br got %b/%h/%h want %b/%h/%h",
               ctl, lu_stall_cnt, br_stall_cnt, e.ctl, e.lu, e.br);
    end
    exp_br = next_cnt(exp_br, 1'b1, 1'b0);
    @(posedge clk); #1;
    apply(mk(OP_R, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, IDLE, 0, 0));
    #1;
    sb.push_back('{HOLD, exp_lu, exp_br});
    e = sb.pop_front();
    vectors++;
    $display("[reset_in_hold 1] ctl=%b lu=%h br=%h", ctl, lu_stall_cnt, br_stall_cnt);
    if ({ctl, lu_stall_cnt, br_stall_cnt} !== {e.ctl, e.lu, e.br}) begin
      miscompares++;
      $display("FAIL reset_in_hold[1] ctl/lu/br got %b/%h/%h want %b/%h/%h",
               ctl, lu_stall_cnt, br_stall_cnt, e.ctl, e.lu, e.br);
    end
    // Asynchronous reset in the middle of HOLD1.
    rst_n = 1'b0;
    #1;
    exp_lu = '0;
    exp_br = '0;
    sb.push_back('{IDLE, exp_lu, exp_br});
    e = sb.pop_front();
    vectors++;
    $display("[reset_in_hold 2] ctl=%b lu=%h br=%h", ctl, lu_stall_cnt, br_stall_cnt);
    if ({ctl, lu_stall_cnt, br_stall_cnt} !== {e.ctl, e.lu, e.br}) begin
      miscompares++;
      $display("FAIL reset_in_hold[2] ctl/lu/br got %b/%h/%h want %b/%h/%h",
               ctl, lu_stall_cnt, br_stall_cnt, e.ctl, e.lu, e.br);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{IDLE, exp_lu, exp_br});
    @(negedge clk);
    e = sb.pop_front();
    vectors++;
    $display("[reset_in_hold 3] ctl=%b lu=%h br=%h", ctl, lu_stall_cnt, br_stall_cnt);
    if ({ctl, lu_stall_cnt, br_stall_cnt} !== {e.ctl, e.lu, e.br}) begin
      miscompares++;
      $display("FAIL reset_in_hold[3] ctl/lu/br got %b/%h/%h want %b/%h/%h",
               ctl, lu_stall_cnt, br_stall_cnt, e.ctl, e.lu, e.br);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu();
    test_back_to_back();
    test_saturation();
    test_reset_in_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
